// File: rtl/rv32m_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow skip the iteration.
module rv32m_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_r;
  state_t          state_nxt_s;
  logic [1:0]      op_r;
  logic            sign_a_r;
  logic            sign_b_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] div_r;
  logic [4:0]      cnt_r;
  logic [XLEN-1:0] result_r;
  logic            out_valid_r;

  logic            accept_s;
  logic            signed_in_s;
  logic            sign_a_in_s;
  logic            sign_b_in_s;
  logic [XLEN-1:0] a_abs_s;
  logic [XLEN-1:0] b_abs_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic            special_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN:0]   shift_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] q_fix_s;
  logic [XLEN-1:0] r_fix_s;
  logic [XLEN-1:0] fix_res_s;

  // Accept decode, operand magnitudes and special-case detection
  always_comb begin
    accept_s    = in_valid && (state_r == IDLE) && !kill;
    signed_in_s = ~op[0];
    sign_a_in_s = signed_in_s & rs1[XLEN-1];
    sign_b_in_s = signed_in_s & rs2[XLEN-1];
    a_abs_s     = sign_a_in_s ? (ZERO - rs1) : rs1;
    b_abs_s     = sign_b_in_s ? (ZERO - rs2) : rs2;
    div_zero_s  = (rs2 == ZERO);
    ovf_s       = signed_in_s && (rs1 == MIN_NEG) && (rs2 == ALL_ONES);
    special_s   = div_zero_s | ovf_s;
    if (div_zero_s) begin
      special_res_s = op[1] ? rs1 : ALL_ONES;
    end else begin
      special_res_s = op[1] ? ZERO : MIN_NEG;
    end
  end

  // One restoring step and the final sign correction
  always_comb begin
    shift_s   = {rem_r, q_r[XLEN-1]};
    trial_s   = shift_s - {1'b0, div_r};
    q_fix_s   = (~op_r[0] && (sign_a_r ^ sign_b_r)) ? (ZERO - q_r) : q_r;
    r_fix_s   = (~op_r[0] && sign_a_r) ? (ZERO - rem_r) : rem_r;
    fix_res_s = op_r[1] ? r_fix_s : q_fix_s;
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; kill overrides every other transition
  always_comb begin
    state_nxt_s = state_r;
    if (kill) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_nxt_s = special_s ? DONE : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == 5'd31) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end
        FIX: state_nxt_s = DONE;
        DONE: begin
          if (out_valid_r && out_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Handshake/stall outputs decoded from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      CALC:    busy     = 1'b1;
      FIX:     busy     = 1'b1;
      DONE:    busy     = 1'b0;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Datapath: operand latch, iteration, result and out_valid registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      op_r        <= 2'd0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      rem_r       <= ZERO;
      q_r         <= ZERO;
      div_r       <= ZERO;
      cnt_r       <= 5'd0;
      result_r    <= ZERO;
      out_valid_r <= 1'b0;
    end else if (kill) begin
      cnt_r       <= 5'd0;
      result_r    <= ZERO;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= op;
            sign_a_r <= sign_a_in_s;
            sign_b_r <= sign_b_in_s;
            rem_r    <= ZERO;
            q_r      <= a_abs_s;
            div_r    <= b_abs_s;
            cnt_r    <= 5'd0;
            if (special_s) begin
              result_r <= special_res_s;
            end
          end
        end
        CALC: begin
          cnt_r <= cnt_r + 5'd1;
          if (!trial_s[XLEN]) begin
            rem_r <= trial_s[XLEN-1:0];
            q_r   <= {q_r[XLEN-2:0], 1'b1};
          end else begin
            rem_r <= shift_s[XLEN-1:0];
            q_r   <= {q_r[XLEN-2:0], 1'b0};
          end
        end
        FIX: begin
          result_r    <= fix_res_s;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          // Special cases enter DONE with out_valid still low; raise it one edge later
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed self-checking bench for rv32m_div_unit.
module tb_rv32m_div_unit;

  logic        ACLK;
  logic        ARESETN;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  rv32m_div_unit #(.XLEN(32)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, counting edges and busy cycles from the current point
  task automatic wait_out(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 32'(busy);
    while (!out_valid && lat < 100) begin
      @(posedge ACLK); #1;
      lat++;
      bcnt += 32'(busy);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int bcnt;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    op        = o;
    rs1       = a;
    rs2       = b;
    out_ready = 1'b1;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    op       = ~o;
    rs1      = 32'hDEADBEEF;
    rs2      = 32'h00000001;
    check({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
    wait_out(lat, bcnt);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bcnt), (exp_lat == 33) ? 32'd33 : 32'd0);
    check({tag, "_res"}, result, exp);
    @(posedge ACLK); #1;
    check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  logic [1:0]  v_op  [15];
  logic [31:0] v_a   [15];
  logic [31:0] v_b   [15];
  logic [31:0] v_exp [15];
  int          v_lat [15];

  initial begin
    int lat;
    int bcnt;
    in_valid  = 1'b0;
    op        = 2'd0;
    rs1       = 32'd0;
    rs2       = 32'd0;
    kill      = 1'b0;
    out_ready = 1'b1;
    ARESETN   = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    v_op[0]  = 2'b01; v_a[0]  = 32'd100;      v_b[0]  = 32'd7;        v_exp[0]  = 32'd14;       v_lat[0]  = 33;
    v_op[1]  = 2'b11; v_a[1]  = 32'd100;      v_b[1]  = 32'd7;        v_exp[1]  = 32'd2;        v_lat[1]  = 33;
    v_op[2]  = 2'b00; v_a[2]  = 32'hFFFFFFF9; v_b[2]  = 32'd2;        v_exp[2]  = 32'hFFFFFFFD; v_lat[2]  = 33;
    v_op[3]  = 2'b10; v_a[3]  = 32'hFFFFFFF9; v_b[3]  = 32'd2;        v_exp[3]  = 32'hFFFFFFFF; v_lat[3]  = 33;
    v_op[4]  = 2'b01; v_a[4]  = 32'hFFFFFFF9; v_b[4]  = 32'd2;        v_exp[4]  = 32'h7FFFFFFC; v_lat[4]  = 33;
    v_op[5]  = 2'b00; v_a[5]  = 32'd5;        v_b[5]  = 32'd0;        v_exp[5]  = 32'hFFFFFFFF; v_lat[5]  = 1;
    v_op[6]  = 2'b01; v_a[6]  = 32'd5;        v_b[6]  = 32'd0;        v_exp[6]  = 32'hFFFFFFFF; v_lat[6]  = 1;
    v_op[7]  = 2'b10; v_a[7]  = 32'd5;        v_b[7]  = 32'd0;        v_exp[7]  = 32'd5;        v_lat[7]  = 1;
    v_op[8]  = 2'b11; v_a[8]  = 32'd5;        v_b[8]  = 32'd0;        v_exp[8]  = 32'd5;        v_lat[8]  = 1;
    v_op[9]  = 2'b00; v_a[9]  = 32'h80000000; v_b[9]  = 32'hFFFFFFFF; v_exp[9]  = 32'h80000000; v_lat[9]  = 1;
    v_op[10] = 2'b10; v_a[10] = 32'h80000000; v_b[10] = 32'hFFFFFFFF; v_exp[10] = 32'd0;        v_lat[10] = 1;
    v_op[11] = 2'b01; v_a[11] = 32'h80000000; v_b[11] = 32'hFFFFFFFF; v_exp[11] = 32'd0;        v_lat[11] = 33;
    v_op[12] = 2'b11; v_a[12] = 32'h80000000; v_b[12] = 32'hFFFFFFFF; v_exp[12] = 32'h80000000; v_lat[12] = 33;
    v_op[13] = 2'b00; v_a[13] = 32'h80000000; v_b[13] = 32'd2;        v_exp[13] = 32'hC0000000; v_lat[13] = 33;
    v_op[14] = 2'b10; v_a[14] = 32'd7;        v_b[14] = 32'hFFFFFFFE; v_exp[14] = 32'd1;        v_lat[14] = 33;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), v_op[i], v_a[i], v_b[i], v_exp[i], v_lat[i]);
    end

    // Back-pressure: result must hold while out_ready is low
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd10; out_ready = 1'b0;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    wait_out(lat, bcnt);
    check("bp_lat", 32'(lat), 32'd33);
    for (int k = 0; k < 10; k++) begin
      @(posedge ACLK); #1;
      check($sformatf("bp_hold%0d", k), {result[29:0], out_valid, in_ready}, {30'd100, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge ACLK); #1;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd9; rs2 = 32'd3;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    check("bp_reaccept_busy", {31'd0, busy}, 32'd1);
    wait_out(lat, bcnt);
    check("bp_second_res", result, 32'd3);
    @(posedge ACLK); #1;

    // kill at CALC count 10
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ACLK);
    #1;
    kill = 1'b1;
    @(posedge ACLK); #1;
    kill = 1'b0;
    check("kill_idle", {29'd0, busy, out_valid, in_ready}, 32'd1);
    repeat (40) @(posedge ACLK);
    #1;
    check("kill_no_ov", {31'd0, out_valid}, 32'd0);

    // Leave a non-zero result behind, then reset mid-CALC
    run_op("pre_rst", 2'b01, 32'd50, 32'd5, 32'd10, 33);
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    check("rst_mid_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
    check("rst_mid_result", result, 32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    run_op("post_rst", 2'b01, 32'd100, 32'd7, 32'd14, 33);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rv32m_div_unit.md
# rv32m_div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits directly downstream of the CPU's execute-stage operand mux. It accepts one operation per valid/ready handshake, computes one quotient bit per cycle using restoring division, and returns a registered result through a second valid/ready handshake to writeback. Divide-by-zero and signed-overflow cases bypass the iteration.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- ACLK  in  1  clock; all state updates on rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1  in  XLEN  dividend.
- rs2  in  XLEN  divisor.
- kill  in  1  pipeline flush; aborts any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  quotient or remainder, selected by the latched op.
- busy  out  1  high in CALC or FIX; used for the CPU stall.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept occurs when in_valid && in_ready && !kill at an edge. At accept, latch op and the operand signs, and load |rs1| and |rs2|.
  - Absolute values are taken only for DIV/REM. For DIVU/REMU the operands load unchanged.
  - The 0x80000000 magnitude is treated as unsigned 2^31.
- Special cases are detected at accept; in both, the next state is DONE directly.
  - Divide by zero (rs2==0): quotient 0xFFFFFFFF, remainder rs1.
  - Signed overflow (DIV/REM, rs1==0x80000000, rs2==0xFFFFFFFF): quotient 0x80000000, remainder 0.
- CALC: 5-bit counter runs from 0 to 31. Each edge performs one restoring step:
  - Form {rem[31:0], q[31]} shifted left by one.
  - Compute a trial subtract of the 33-bit partial remainder minus the divisor.
  - If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore.
  - When count==31, go to FIX.
- FIX: apply the sign correction and register the result.
  - Quotient is negated if signed && (sign_a ^ sign_b).
  - Remainder is negated if signed && sign_a.
  - REM/REMU select the remainder; DIV/DIVU select the quotient. Next state is DONE.
- DONE: out_valid=1 and result is held stable. When out_ready=1 at an edge, go to IDLE. No new accept happens in DONE.
- kill at any edge: next state is IDLE, out_valid=0, and the result is discarded. kill takes priority over an accept and over an out handshake in the same cycle.
- Reset (ARESETN=0 at an edge), including mid-operation, forces:
  - state IDLE, counter 0, out_valid 0, result 0, busy 0.
  - in_ready=1 from the first cycle after reset.

## Timing
- in_ready and busy are decoded combinationally from the state register. All other outputs are registered.
- Normal operation, with accept at edge N:
  - CALC steps occur on edges N+1..N+32.
  - FIX occurs on edge N+33.
  - out_valid is high from after edge N+33. This gives 33 cycles from accept to out_valid.
- Special case, with accept at edge N: out_valid is high from after edge N+1.
- With out_ready held high, a DONE→IDLE transition is followed by the earliest next accept one edge later. Throughput is one operation per 35 cycles (normal) or 3 cycles (special).
- When out_ready is low, DONE holds indefinitely. result and out_valid must not change until the handshake edge.
- Inputs rs1, rs2 and op are sampled only at the accept edge. Changes after that edge have no effect.

## Test plan
- Reset then DIVU: rs1=100, rs2=7, accept at edge N. Required: out_valid after N+33, result=14. REMU with the same operands gives 2. busy is high for exactly 33 cycles.
- Signed operations with rs1=0xFFFFFFF9 (-7), rs2=2:
  - DIV gives 0xFFFFFFFD (-3).
  - REM gives 0xFFFFFFFF (-1).
  - DIVU gives 0x7FFFFFFC.
- Divide by zero with rs1=5, rs2=0:
  - DIV and DIVU give 0xFFFFFFFF.
  - REM and REMU give 5.
  - out_valid appears one cycle after accept.
- Overflow with rs1=0x80000000, rs2=0xFFFFFFFF:
  - DIV gives 0x80000000 and REM gives 0.
  - The same operands under DIVU give 0 and REMU gives 0x80000000, taking 33 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Required: result stable, in_ready=0. Then raise out_ready; the unit returns to IDLE next edge and a new accept succeeds one edge later.
- Abort cases: assert kill at CALC count 10, which must give IDLE next edge with no out_valid. Separately, drive ARESETN=0 mid-CALC, which must give out_valid=0, result=0, in_ready=1. A subsequent 100/7 must still yield 14.
